alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared multi-cycle 5-bit ALU
`timescale 1ns/1ps

module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] a0,
  input  logic [4:0] b0,
  input  logic [4:0] a1,
  input  logic [4:0] b1,
  input  logic       op0,
  input  logic       op1,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  output logic       alu_op,
  input  logic [5:0] alu_result,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [5:0] result,
  output logic       busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [1:0] CNT_LAST = 2'(ALU_LAT - 1);

  state_t     state_q;
  logic       ptr_q;
  logic       sel_q;
  logic [1:0] cnt_q;
  logic [4:0] alu_a_q, alu_b_q;
  logic       alu_op_q;
  logic [5:0] result_q;
  logic       gnt0_q, gnt1_q, done0_q, done1_q, busy_q;

  logic       any_req_d;
  logic       pick_d;

  // ptr_q holds the last served requester; on a tie the other one wins.
  always_comb begin
    any_req_d = req0 | req1;
    if (req0 && req1) pick_d = ~ptr_q;
    else              pick_d = req1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      sel_q    <= 1'b0;
      cnt_q    <= 2'd0;
      alu_a_q  <= 5'd0;
      alu_b_q  <= 5'd0;
      alu_op_q <= 1'b0;
      result_q <= 6'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            sel_q    <= pick_d;
            gnt0_q   <= ~pick_d;
            gnt1_q   <= pick_d;
            alu_a_q  <= pick_d ? a1  : a0;
            alu_b_q  <= pick_d ? b1  : b0;
            alu_op_q <= pick_d ? op1 : op0;
            busy_q   <= 1'b1;
            cnt_q    <= 2'd0;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == CNT_LAST) begin
            result_q <= alu_result;
            done0_q  <= ~sel_q;
            done1_q  <= sel_q;
            ptr_q    <= sel_q;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign result = result_q;
  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with ALU_LAT=1 and ALU_LAT=3 lanes
`timescale 1ns/1ps

module tb_alu_arbiter;

  typedef struct {
    int who;
    int a;
    int b;
    int op;
    int g_edge;
    int d_edge;
    int res;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int l, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %0d expected %0d", name, l, act, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    if (op != 0) return (((a - b) % 64) + 64) % 64;
    return (a + b) % 64;
  endfunction

  for (genvar L = 0; L < 2; L++) begin : lane
    localparam int LAT = (L == 0) ? 1 : 3;

    logic       rst_n;
    logic       req0, req1, op0, op1;
    logic [4:0] a0, b0, a1, b1;
    logic [4:0] alu_a, alu_b;
    logic       alu_op;
    logic [5:0] alu_result;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [5:0] result;
    logic [5:0] alu_now;
    logic [5:0] pipe [2];
    bit         fin = 1'b0;

    alu_arbiter #(.ALU_LAT(LAT)) dut (
      .clk(clk), .reset(rst_n),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .op0(op0), .op1(op1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .busy(busy)
    );

    // Shared ALU stand-in: result appears LAT cycles after its operands.
    assign alu_now = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    always @(posedge clk) begin
      pipe[0] <= alu_now;
      pipe[1] <= pipe[0];
    end
    if (LAT == 1) begin : g_comb
      assign alu_result = alu_now;
    end else begin : g_pipe
      assign alu_result = pipe[LAT-2];
    end

    // Reference model: one op at a time, next grant no earlier than done+1.
    txn_t gq[$];
    txn_t dq[$];
    txn_t cur;
    txn_t nt;
    txn_t mt;
    int   edge_n = 0;
    int   next_free = 0;
    int   last = 1;
    bit   active = 1'b0;
    int   exp_a = 0, exp_b = 0, exp_op = 0, exp_res = 0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gq.delete();
        dq.delete();
        next_free = 0;
        last = 1;
        active = 1'b0;
        exp_a = 0; exp_b = 0; exp_op = 0; exp_res = 0;
      end else begin
        edge_n++;
        if (active && edge_n == cur.d_edge) begin
          exp_res = cur.res;
          last = cur.who;
          active = 1'b0;
        end
        if (edge_n >= next_free && (req0 || req1)) begin
          nt.who = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
          nt.a   = nt.who ? int'(a1)  : int'(a0);
          nt.b   = nt.who ? int'(b1)  : int'(b0);
          nt.op  = nt.who ? int'(op1) : int'(op0);
          nt.g_edge = edge_n;
          nt.d_edge = edge_n + LAT;
          nt.res = ref_alu(nt.a, nt.b, nt.op);
          gq.push_back(nt);
          dq.push_back(nt);
          cur = nt;
          active = 1'b1;
          next_free = nt.d_edge + 1;
          exp_a = nt.a; exp_b = nt.b; exp_op = nt.op;
        end
      end
    end

    task automatic zero_check();
      chk("reset_outputs", L,
          int'({alu_a, alu_b, alu_op, gnt0, gnt1, done0, done1, result, busy}), 0);
    endtask

    always @(negedge clk) begin
      if (!rst_n) begin
        zero_check();
      end else begin
        chk("gnt_exclusive", L, int'(gnt0 & gnt1), 0);
        chk("done_exclusive", L, int'(done0 & done1), 0);
        chk("busy", L, int'(busy), int'(active));
        chk("alu_a", L, int'(alu_a), exp_a);
        chk("alu_b", L, int'(alu_b), exp_b);
        chk("alu_op", L, int'(alu_op), exp_op);
        chk("result_hold", L, int'(result), exp_res);
        if (gnt0 || gnt1) begin
          if (gq.size() == 0) chk("unexpected_gnt", L, 1, 0);
          else begin
            mt = gq.pop_front();
            chk("gnt_who", L, int'(gnt1), mt.who);
            chk("gnt_edge", L, edge_n, mt.g_edge);
          end
        end
        while (gq.size() > 0 && gq[0].g_edge <= edge_n) begin
          mt = gq.pop_front();
          chk("missing_gnt", L, 0, 1);
        end
        if (done0 || done1) begin
          if (dq.size() == 0) chk("unexpected_done", L, 1, 0);
          else begin
            mt = dq.pop_front();
            chk("done_who", L, int'(done1), mt.who);
            chk("done_edge", L, edge_n, mt.d_edge);
            chk("done_result", L, int'(result), mt.res);
          end
        end
        while (dq.size() > 0 && dq[0].d_edge <= edge_n) begin
          mt = dq.pop_front();
          chk("missing_done", L, 0, 1);
        end
      end
    end

    task automatic set_req(input int who, input bit v);
      if (who == 0) req0 = v; else req1 = v;
    endtask

    task automatic set_ops(input int who, input int a, input int b, input int op);
      if (who == 0) begin a0 = 5'(a); b0 = 5'(b); op0 = 1'(op); end
      else          begin a1 = 5'(a); b1 = 5'(b); op1 = 1'(op); end
    endtask

    task automatic wait_gnt(input int who);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = (who == 0) ? gnt0 : gnt1;
      end
      if (!seen) chk("gnt_timeout", L, 0, 1);
    endtask

    task automatic wait_done(input int who, input int exp);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = (who == 0) ? done0 : done1;
      end
      if (!seen) chk("done_timeout", L, 0, 1);
      else chk("known_result", L, int'(result), exp);
    endtask

    task automatic pulse_reset(input int hold);
      #1 rst_n = 1'b0;
      #1 zero_check();
      repeat (hold) @(negedge clk);
      #1 rst_n = 1'b1;
    endtask

    initial begin
      int ng;
      int cyc;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      set_ops(0, 0, 0, 0);
      set_ops(1, 0, 0, 0);
      repeat (3) @(negedge clk);
      zero_check();
      #1 rst_n = 1'b1;
      @(negedge clk);

      set_ops(0, 7, 9, 0); set_req(0, 1'b1);
      wait_gnt(0);
      set_req(0, 1'b0);
      set_ops(1, 31, 31, 0); set_req(1, 1'b1);
      wait_done(0, 16);
      wait_gnt(1);
      set_ops(1, 3, 5, 1);
      wait_done(1, 62);
      wait_gnt(1);
      set_req(1, 1'b0);
      wait_done(1, 62);

      set_ops(0, 10, 4, 1); set_ops(1, 20, 30, 0);
      set_req(0, 1'b1); set_req(1, 1'b1);
      ng = 0; cyc = 0;
      while (ng < 4 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (gnt0 || gnt1) begin
          chk("rr_order", L, int'(gnt1), ng % 2);
          ng++;
        end
      end
      if (ng < 4) chk("held_grants", L, ng, 4);
      set_req(0, 1'b0); set_req(1, 1'b0);
      repeat (LAT + 2) @(negedge clk);

      fork
        begin
          for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            set_ops(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1));
            set_req(0, 1'b1);
            wait_gnt(0);
            set_req(0, 1'b0);
          end
        end
        begin
          for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            set_ops(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1));
            set_req(1, 1'b1);
            wait_gnt(1);
            set_req(1, 1'b0);
          end
        end
        begin
          for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(30, 90)) @(negedge clk);
            pulse_reset($urandom_range(1, 2));
          end
        end
      join
      repeat (LAT + 2) @(negedge clk);

      set_ops(0, 12, 6, 0); set_req(0, 1'b1);
      wait_gnt(0);
      set_req(0, 1'b0);
      set_ops(1, 9, 2, 1); set_req(1, 1'b1);
      pulse_reset(1);
      wait_gnt(1);
      set_req(1, 1'b0);
      wait_done(1, 7);
      repeat (LAT + 3) @(negedge clk);
      chk("gq_drained", L, gq.size(), 0);
      chk("dq_drained", L, dq.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int cyc = 0;
    while (!(lane[0].fin && lane[1].fin) && cyc < 50000) begin
      @(negedge clk);
      cyc++;
    end
    if (!(lane[0].fin && lane[1].fin)) chk("lanes_finished", -1, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
